// File: rtl/minisys_id_stage.sv
// Decode stage: register file, jump resolution, load-use detection and the ID/EX register.
// Optional macro ID_RF_BYPASS_EN: write-first forwarding of the WB write into the register-file reads.
module minisys_id_stage #(
    parameter int RF_DEPTH = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [31:0]   instrD,
    input  logic [DW-1:0] pcplus4D,
    input  logic          wb_we,
    input  logic [4:0]    wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    input  logic          branchM,
    input  logic          keepmdE,
    output logic          load_use,
    output logic          jumpI,
    output logic [DW-1:0] pc_jumpI,
    output logic          validE,
    output logic [5:0]    opE,
    output logic [5:0]    funcE,
    output logic [4:0]    rsE,
    output logic [4:0]    rtE,
    output logic [4:0]    rdE,
    output logic [4:0]    shamtE,
    output logic [DW-1:0] rsdataE,
    output logic [DW-1:0] rtdataE,
    output logic [DW-1:0] immE,
    output logic [DW-1:0] pcplus4E,
    output logic          memreadE
);

    logic [DW-1:0] rf_q [0:RF_DEPTH-1];

    logic [5:0]    op_d;
    logic [5:0]    func_d;
    logic [4:0]    rs_d;
    logic [4:0]    rt_d;
    logic          rs_hit;
    logic          rt_hit;
    logic [DW-1:0] rsdata_d;
    logic [DW-1:0] rtdata_d;
    logic [DW-1:0] imm_d;
    logic          memread_d;
    logic          is_j;
    logic          is_jr;

    logic          valid_q;
    logic [5:0]    op_q;
    logic [5:0]    func_q;
    logic [4:0]    rs_q;
    logic [4:0]    rt_q;
    logic [4:0]    rd_q;
    logic [4:0]    shamt_q;
    logic [DW-1:0] rsdata_q;
    logic [DW-1:0] rtdata_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] pcplus4_q;
    logic          memread_q;

    assign op_d   = instrD[31:26];
    assign func_d = instrD[5:0];
    assign rs_d   = instrD[25:21];
    assign rt_d   = instrD[20:16];

    // Register 0 is never written, so its reset value keeps it at zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else if (wb_we && (wb_waddr != 5'd0)) begin
            rf_q[wb_waddr] <= wb_wdata;
        end
    end

`ifdef ID_RF_BYPASS_EN
    assign rs_hit = wb_we && (wb_waddr == rs_d) && (rs_d != 5'd0);
    assign rt_hit = wb_we && (wb_waddr == rt_d) && (rt_d != 5'd0);
`else
    assign rs_hit = 1'b0;
    assign rt_hit = 1'b0;
`endif

    assign rsdata_d = (rs_d == 5'd0) ? '0 : (rs_hit ? wb_wdata : rf_q[rs_d]);
    assign rtdata_d = (rt_d == 5'd0) ? '0 : (rt_hit ? wb_wdata : rf_q[rt_d]);

    // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
    assign imm_d = (op_d == 6'b001100 || op_d == 6'b001101 || op_d == 6'b001110)
                 ? {{(DW-16){1'b0}}, instrD[15:0]}
                 : {{(DW-16){instrD[15]}}, instrD[15:0]};

    assign memread_d = (op_d == 6'b100011);

    assign is_j  = (op_d == 6'b000010) || (op_d == 6'b000011);
    assign is_jr = (op_d == 6'b000000) && (func_d == 6'b001000);

    assign load_use = valid_q && memread_q && (rt_q != 5'd0)
                   && ((rt_q == rs_d) || (rt_q == rt_d));

    // Suppressed during a stall so jr never uses the not-yet-loaded rs value.
    assign jumpI    = (is_j || is_jr) && !load_use;
    assign pc_jumpI = is_j  ? {pcplus4D[DW-1:DW-4], instrD[25:0], 2'b00}
                    : is_jr ? rsdata_d
                    : '0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q   <= 1'b0;
            op_q      <= '0;
            func_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            rsdata_q  <= '0;
            rtdata_q  <= '0;
            imm_q     <= '0;
            pcplus4_q <= '0;
            memread_q <= 1'b0;
        end else if (branchM || (!keepmdE && load_use)) begin
            valid_q   <= 1'b0;
            op_q      <= '0;
            func_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            shamt_q   <= '0;
            rsdata_q  <= '0;
            rtdata_q  <= '0;
            imm_q     <= '0;
            pcplus4_q <= '0;
            memread_q <= 1'b0;
        end else if (!keepmdE) begin
            valid_q   <= 1'b1;
            op_q      <= op_d;
            func_q    <= func_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= instrD[15:11];
            shamt_q   <= instrD[10:6];
            rsdata_q  <= rsdata_d;
            rtdata_q  <= rtdata_d;
            imm_q     <= imm_d;
            pcplus4_q <= pcplus4D;
            memread_q <= memread_d;
        end
    end

    assign validE   = valid_q;
    assign opE      = op_q;
    assign funcE    = func_q;
    assign rsE      = rs_q;
    assign rtE      = rt_q;
    assign rdE      = rd_q;
    assign shamtE   = shamt_q;
    assign rsdataE  = rsdata_q;
    assign rtdataE  = rtdata_q;
    assign immE     = imm_q;
    assign pcplus4E = pcplus4_q;
    assign memreadE = memread_q;

endmodule

// File: tb/tb_minisys_id_stage.sv
// Directed bench for minisys_id_stage: ID/EX expectations queued at drive time, popped after each edge.
module tb_minisys_id_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        branchM;
    logic        keepmdE;
    logic        load_use;
    logic        jumpI;
    logic [31:0] pc_jumpI;
    logic        validE;
    logic [5:0]  opE;
    logic [5:0]  funcE;
    logic [4:0]  rsE;
    logic [4:0]  rtE;
    logic [4:0]  rdE;
    logic [4:0]  shamtE;
    logic [31:0] rsdataE;
    logic [31:0] rtdataE;
    logic [31:0] immE;
    logic [31:0] pcplus4E;
    logic        memreadE;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic        memread;
    } ide_t;

    ide_t        obs;
    ide_t        sb [$];
    ide_t        last_e;
    ide_t        e;
    logic [31:0] mrf [0:31];
    int          checks = 0;
    int          errors = 0;

    minisys_id_stage dut (
        .clk(clk), .clrn(clrn), .instrD(instrD), .pcplus4D(pcplus4D),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .branchM(branchM), .keepmdE(keepmdE), .load_use(load_use),
        .jumpI(jumpI), .pc_jumpI(pc_jumpI), .validE(validE), .opE(opE),
        .funcE(funcE), .rsE(rsE), .rtE(rtE), .rdE(rdE), .shamtE(shamtE),
        .rsdataE(rsdataE), .rtdataE(rtdataE), .immE(immE),
        .pcplus4E(pcplus4E), .memreadE(memreadE)
    );

    assign obs = {validE, opE, funcE, rsE, rtE, rdE, shamtE,
                  rsdataE, rtdataE, immE, pcplus4E, memreadE};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ide_t dec(input logic [31:0] ins, input logic [31:0] pc4,
                                 input logic [31:0] imm);
        ide_t r;
        r.valid   = 1'b1;
        r.op      = ins[31:26];
        r.func    = ins[5:0];
        r.rs      = ins[25:21];
        r.rt      = ins[20:16];
        r.rd      = ins[15:11];
        r.shamt   = ins[10:6];
        r.rsd     = mrf[ins[25:21]];
        r.rtd     = mrf[ins[20:16]];
        r.imm     = imm;
        r.pc4     = pc4;
        r.memread = (ins[31:26] == 6'b100011);
        return r;
    endfunction

    task automatic push(input ide_t x);
        sb.push_back(x);
        last_e = x;
    endtask

    task automatic step(input string tag);
        ide_t x;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            x = sb.pop_front();
            chk(tag, obs, x);
            $display("step %-12s validE=%0b op=%h rsdata=%h rtdata=%h imm=%h",
                     tag, validE, opE, rsdataE, rtdataE, immE);
        end
    endtask

    task automatic set_in(input logic [31:0] ins, input logic [31:0] pc4);
        instrD   = ins;
        pcplus4D = pc4;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_we    = 1'b1;
        wb_waddr = a;
        wb_wdata = d;
        set_in(32'h0, 32'h0);
        push(dec(32'h0, 32'h0, 32'h0));
        step("wr_nop");
        if (a != 5'd0) mrf[a] = d;
        wb_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        clrn = 1'b0; instrD = 32'h0; pcplus4D = 32'h0; wb_we = 1'b0;
        wb_waddr = 5'd0; wb_wdata = 32'h0; branchM = 1'b0; keepmdE = 1'b0;
        last_e = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_idex", obs, '0);
        chk("reset_lu", load_use, 1'b0);
        clrn = 1'b1;

        wr(5'd5, 32'h1234ABCD);
        wr(5'd6, 32'h00000055);
        wr(5'd7, 32'h00001111);
        wr(5'd8, 32'h00000080);

        // immediates
        set_in(32'h20A6FFFF, 32'h00400010);
        chk("addi_jump", {jumpI, pc_jumpI}, 33'h0);
        push(dec(32'h20A6FFFF, 32'h00400010, 32'hFFFFFFFF));
        step("addi");
        chk("addi_rsdata", rsdataE, 32'h1234ABCD);
        set_in(32'h30A6FFFF, 32'h00400014);
        push(dec(32'h30A6FFFF, 32'h00400014, 32'h0000FFFF));
        step("andi");
        set_in(32'h34A68000, 32'h00400018);
        push(dec(32'h34A68000, 32'h00400018, 32'h00008000));
        step("ori");
        set_in(32'h38A68001, 32'h0040001C);
        push(dec(32'h38A68001, 32'h0040001C, 32'h00008001));
        step("xori");

        // jumps
        set_in(32'h08000040, 32'h00400004);
        chk("j_target", {jumpI, pc_jumpI}, {1'b1, 32'h00000100});
        push(dec(32'h08000040, 32'h00400004, 32'h00000040));
        step("j");
        set_in(32'h0C000001, 32'hA0000004);
        chk("jal_target", {jumpI, pc_jumpI}, {1'b1, 32'hA0000004});
        push(dec(32'h0C000001, 32'hA0000004, 32'h00000001));
        step("jal");
        set_in(32'h00A00008, 32'h00400020);
        chk("jr_target", {jumpI, pc_jumpI}, {1'b1, 32'h1234ABCD});
        push(dec(32'h00A00008, 32'h00400020, 32'h00000008));
        step("jr");

        // load-use stall then retry
        set_in(32'h8C280004, 32'h00400030);
        push(dec(32'h8C280004, 32'h00400030, 32'h00000004));
        step("lw8");
        set_in(32'h01024820, 32'h00400034);
        chk("lu_assert", load_use, 1'b1);
        push('0);
        step("lu_bubble");
        #1;
        chk("lu_release", load_use, 1'b0);
        push(dec(32'h01024820, 32'h00400034, 32'h00004820));
        step("add_after");

        // lw to $0 never stalls
        set_in(32'h8C200000, 32'h00400040);
        push(dec(32'h8C200000, 32'h00400040, 32'h00000000));
        step("lw0");
        set_in(32'h00004820, 32'h00400044);
        chk("lu_rt0", load_use, 1'b0);
        push(dec(32'h00004820, 32'h00400044, 32'h00004820));
        step("add_r0");

        // jr behind a load of its rs waits, then retakes the jump
        set_in(32'h8C280004, 32'h00400050);
        push(dec(32'h8C280004, 32'h00400050, 32'h00000004));
        step("lw8_jr");
        set_in(32'h01000008, 32'h00400054);
        chk("jr_stall", {load_use, jumpI}, 2'b10);
        push('0);
        step("jr_bubble");
        #1;
        chk("jr_retake", {load_use, jumpI, pc_jumpI}, {2'b01, 32'h00000080});
        push(dec(32'h01000008, 32'h00400054, 32'h00000008));
        step("jr8");

        // keepmdE holds even while a load-use stall is pending
        set_in(32'h8C280004, 32'h00400060);
        push(dec(32'h8C280004, 32'h00400060, 32'h00000004));
        step("lw8_keep");
        keepmdE = 1'b1;
        set_in(32'h01024820, 32'h00400064);
        chk("keep_lu", load_use, 1'b1);
        push(last_e);
        step("keep_hold");
        keepmdE = 1'b0;
        #1;
        chk("keep_lu_stays", load_use, 1'b1);
        push('0);
        step("keep_bubble");
        #1;
        push(dec(32'h01024820, 32'h00400064, 32'h00004820));
        step("keep_add");

        // keepmdE alone holds; branchM overrides it
        set_in(32'h34A68000, 32'h00400070);
        push(dec(32'h34A68000, 32'h00400070, 32'h00008000));
        step("ori_b");
        keepmdE = 1'b1;
        set_in(32'h38A68001, 32'h00400074);
        push(last_e);
        step("keep_only");
        branchM = 1'b1;
        #1;
        push('0);
        step("br_keep");
        branchM = 1'b0;
        keepmdE = 1'b0;

        // same-cycle WB write vs ID read
        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h0000DEAD;
        set_in(32'h00E00020, 32'h00400080);
        e = dec(32'h00E00020, 32'h00400080, 32'h00000020);
`ifdef ID_RF_BYPASS_EN
        e.rsd = 32'h0000DEAD;
`else
        e.rsd = 32'h00001111;
`endif
        push(e);
        step("wb_read");
        mrf[7] = 32'h0000DEAD;
        wb_wdata = 32'h0000BEEF;
        set_in(32'h00E00008, 32'h00400084);
        e = dec(32'h00E00008, 32'h00400084, 32'h00000008);
`ifdef ID_RF_BYPASS_EN
        e.rsd = 32'h0000BEEF;
`else
        e.rsd = 32'h0000DEAD;
`endif
        chk("wb_jr", pc_jumpI, e.rsd);
        push(e);
        step("wb_jr_e");
        mrf[7] = 32'h0000BEEF;
        wb_waddr = 5'd0; wb_wdata = 32'hFFFFFFFF;
        set_in(32'h00000020, 32'h00400088);
        push(dec(32'h00000020, 32'h00400088, 32'h00000020));
        step("wr_r0");
        wb_we = 1'b0;
        #1;
        push(dec(32'h00000020, 32'h00400088, 32'h00000020));
        step("rd_r0");
        set_in(32'h00E70020, 32'h0040008C);
        push(dec(32'h00E70020, 32'h0040008C, 32'h00000020));
        step("rd_r7");

        // asynchronous reset in the middle of a stall
        set_in(32'h8C280004, 32'h00400090);
        push(dec(32'h8C280004, 32'h00400090, 32'h00000004));
        step("lw8_rst");
        set_in(32'h01024820, 32'h00400094);
        chk("rst_lu_pre", load_use, 1'b1);
        clrn = 1'b0;
        #1;
        chk("rst_async", obs, '0);
        chk("rst_lu", load_use, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_held", obs, '0);
        clrn = 1'b1;
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            logic [4:0]  a;
            logic [31:0] ins;
            a   = i[4:0];
            ins = {6'b000000, a, a, 5'd0, 5'd0, 6'b100000};
            set_in(ins, 32'h00400100);
            push(dec(ins, 32'h00400100, {{16{ins[15]}}, ins[15:0]}));
            step("rf_clear");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
